mem_copy_engine: RTL and testbench

//  Initiator for the 32x32 data-memory port (addrRe/addr/write_data/MemRead/MemWrite/read_data).
//  On a start pulse it either copies LEN words from SRC to DST or fills LEN words at DST with a constant.

---
 rtl/mem_copy_engine_pkg.sv | 20 ++
 rtl/mem_copy_engine_if.sv | 36 +++
 rtl/mem_copy_engine.sv | 194 +++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// rtl/mem_copy_engine_pkg.sv - shared types and constants for the memory copy/fill engine
package mem_copy_engine_pkg;

  // Defaults matching the 32x32 data-memory instance
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

  // Operation select on the mode input
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Engine sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - data-memory port bundle between the engine and the memory
interface mem_copy_engine_if
  import mem_copy_engine_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic [AW-1:0] mem_addrRe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] mem_read_data;

  // Engine side: drives addresses, data and enables, receives read data
  modport master (
    output mem_addrRe,
    output mem_addr,
    output mem_write_data,
    output MemRead,
    output MemWrite,
    input  mem_read_data
  );

  // Memory side: the responder
  modport slave (
    input  mem_addrRe,
    input  mem_addr,
    input  mem_write_data,
    input  MemRead,
    input  MemWrite,
    output mem_read_data
  );

endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - memory copy/fill initiator owning the data-memory port while busy
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [AW-1:0]     src_base,
  input  logic [AW-1:0]     dst_base,
  input  logic [AW:0]       len,
  input  logic [DW-1:0]     fill_value,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW:0]       words_done,
  mem_copy_engine_if.master mem
);

  // Full memory depth; len above this is rejected
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ZERO  = '0;

  // Sequencer state
  state_e state_q, state_d;

  // Latched operation arguments
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] fill_q, fill_d;

  // Word index and copy buffer
  logic [AW:0]   idx_q, idx_d;
  logic [DW-1:0] buf_q, buf_d;

  // Registered status outputs
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW:0]   wdone_q, wdone_d;

  // Registered memory-port outputs
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;

  // Low bits of the next index; address arithmetic wraps modulo the depth
  logic [AW-1:0] idx_lo_d;
  logic          last_word;

  assign idx_lo_d  = idx_d[AW-1:0];
  assign last_word = ((idx_q + ONE) == len_q);

  // Next-state and datapath: sequencing plus next values for all registered outputs
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    wdone_d = wdone_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len > DEPTH) begin
            // Rejected request: report and stay idle, memory untouched
            err_d = 1'b1;
          end else if (len == ZERO) begin
            wdone_d = ZERO;
            state_d = ST_FIN;
          end else begin
            mode_d  = mode;
            src_d   = src_base;
            dst_d   = dst_base;
            len_d   = len;
            fill_d  = fill_value;
            idx_d   = ZERO;
            wdone_d = ZERO;
            state_d = (mode == MODE_FILL) ? ST_WR : ST_RD;
          end
        end
      end

      ST_RD: begin
        // Read data is combinational while MemRead is high; capture it at the closing edge
        buf_d   = mem.mem_read_data;
        state_d = ST_WR;
      end

      ST_WR: begin
        idx_d   = idx_q + ONE;
        wdone_d = wdone_q + ONE;
        if (last_word) begin
          state_d = ST_FIN;
        end else if (mode_q == MODE_FILL) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so the port never glitches
    mem_rd_d = (state_d == ST_RD);
    mem_wr_d = (state_d == ST_WR);
    busy_d   = (state_d == ST_RD) || (state_d == ST_WR);
    done_d   = (state_d == ST_FIN);

    // Read address moves only when the next cycle reads
    rd_addr_d = mem_rd_d ? (src_d + idx_lo_d) : rd_addr_q;

    // Write address/data move only on edges that open a write cycle, so they
    // are stable for the whole time MemWrite is high
    wr_addr_d = mem_wr_d ? (dst_d + idx_lo_d) : wr_addr_q;
    if (mem_wr_d) begin
      wr_data_d = (mode_d == MODE_FILL) ? fill_d : buf_d;
    end else begin
      wr_data_d = wr_data_q;
    end
  end

  // State and datapath registers; reset clears everything and drops the enables at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wdone_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wdone_q   <= wdone_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign words_done         = wdone_q;
  assign mem.mem_addrRe     = rd_addr_q;
  assign mem.mem_addr       = wr_addr_q;
  assign mem.mem_write_data = wr_data_q;
  assign mem.MemRead        = mem_rd_q;
  assign mem.MemWrite       = mem_wr_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for the memory copy/fill engine
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   len;
  logic [DW-1:0] fill_value;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_done;

  mem_copy_engine_if #(.AW(AW), .DW(DW)) mif ();

  mem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len        (len),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int sc; int lat; int wd; bit chk_wd; } done_t;

  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  done_t         dq[$];
  int            eq[$];

  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int  checks  = 0;
  int  errors  = 0;
  int  cyc     = 0;
  int  pending = 0;
  int  wr_seen = 0;
  time t_edge  = 0;
  bit  glitch  = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  wr_t           mw;
  logic [AW-1:0] mr;
  done_t         md;
  int            me;

  // Data memory responder: combinational read, write while MemWrite is high
  assign mif.mem_read_data = mif.MemRead ? mem_arr[mif.mem_addrRe] : '0;
  always @(posedge clk) if (mif.MemWrite) mem_arr[mif.mem_addr] <= mif.mem_write_data;

  always @(posedge clk) begin
    cyc    = cyc + 1;
    t_edge = $time;
  end

  // Any write-port change away from a clock edge while MemWrite is high is a hazard
  always @(mif.mem_addr or mif.mem_write_data) begin
    if (!rst && mif.MemWrite && ($time != t_edge)) glitch = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, write, done or err
  always @(negedge clk) begin
    if (rst) begin
      prev_addr = mif.mem_addr;
      prev_data = mif.mem_write_data;
      glitch    = 1'b0;
    end else begin
      if (mif.MemWrite) begin
        wr_seen = wr_seen + 1;
        chk("write_stable", {63'd0, glitch}, 64'd0);
        glitch = 1'b0;
        chk("busy_in_write", {63'd0, busy}, 64'd1);
        if (wq.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          mw = wq.pop_front();
          chk("write_addr", {59'd0, mif.mem_addr}, {59'd0, mw.a});
          chk("write_data", {32'd0, mif.mem_write_data}, {32'd0, mw.d});
        end
      end else begin
        chk("write_port_hold", {27'd0, mif.mem_addr, mif.mem_write_data},
            {27'd0, prev_addr, prev_data});
      end
      if (mif.MemRead) begin
        chk("read_write_exclusive", {63'd0, mif.MemWrite}, 64'd0);
        if (rq.size() == 0) begin
          chk("unexpected_read", 64'd1, 64'd0);
        end else begin
          mr = rq.pop_front();
          chk("read_addr", {59'd0, mif.mem_addrRe}, {59'd0, mr});
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          md = dq.pop_front();
          chk("done_latency", 64'(cyc - md.sc), 64'(md.lat));
          if (md.chk_wd) chk("words_done", {58'd0, words_done}, 64'(md.wd));
          chk("busy_at_done", {63'd0, busy}, 64'd0);
          pending = pending - 1;
        end
      end
      if (err) begin
        if (eq.size() == 0) begin
          chk("unexpected_err", 64'd1, 64'd0);
        end else begin
          me = eq.pop_front();
          chk("err_latency", 64'(cyc - me), 64'd1);
          chk("busy_at_err", {63'd0, busy}, 64'd0);
          pending = pending - 1;
        end
      end
      prev_addr = mif.mem_addr;
      prev_data = mif.mem_write_data;
    end
  end

  task automatic poke(input int a, input logic [DW-1:0] v);
    mem_arr[a] <= v;
    ref_mem[a] = v;
  endtask

  // Drive one start and push the reference model's expected reads, writes and completion.
  // nwr limits the writes expected (-1 = all); exp_end=0 expects no done.
  task automatic issue(input bit m, input int s, input int d, input int l,
                       input logic [DW-1:0] fv, input int nwr, input bit exp_end);
    int nw;
    int nr;
    int a;
    logic [DW-1:0] v;
    @(negedge clk);
    start      = 1'b1;
    mode       = m;
    src_base   = AW'(s);
    dst_base   = AW'(d);
    len        = (AW+1)'(l);
    fill_value = fv;
    if (l > DEPTH) begin
      eq.push_back(cyc);
      pending = pending + 1;
    end else begin
      nw = (nwr < 0 || nwr > l) ? l : nwr;
      if (m == MODE_FILL) nr = 0;
      else nr = (nw + 1 < l) ? nw + 1 : l;
      for (int k = 0; k < nr; k++) rq.push_back(AW'((s + k) % DEPTH));
      for (int k = 0; k < nw; k++) begin
        a = (d + k) % DEPTH;
        v = (m == MODE_FILL) ? fv : ref_mem[(s + k) % DEPTH];
        ref_mem[a] = v;
        wq.push_back('{a: AW'(a), d: v});
      end
      if (exp_end) begin
        dq.push_back('{sc: cyc, lat: (l == 0) ? 1 : ((m == MODE_FILL) ? l + 1 : 2 * l + 1),
                       wd: l, chk_wd: (l != 0)});
        pending = pending + 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (pending > 0) begin
      chk("completion_timeout", 64'(pending), 64'd0);
      pending = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic settle_and_compare(input string tag);
    wait_idle();
    chk({tag, "_writes_left"}, 64'(wq.size()), 64'd0);
    chk({tag, "_reads_left"}, 64'(rq.size()), 64'd0);
    wq.delete();
    rq.delete();
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("%s_mem[%0d]", tag, i), {32'd0, mem_arr[i]}, {32'd0, ref_mem[i]});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_base;
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    src_base   = '0;
    dst_base   = '0;
    len        = '0;
    fill_value = '0;
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_words_done", {58'd0, words_done}, 64'd0);
    chk("rst_memread", {63'd0, mif.MemRead}, 64'd0);
    chk("rst_memwrite", {63'd0, mif.MemWrite}, 64'd0);
    chk("rst_ports", {22'd0, mif.mem_addrRe, mif.mem_addr, mif.mem_write_data}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Copy without wrap
    poke(2, 32'hAAAA_0001);
    poke(3, 32'hBBBB_0002);
    poke(4, 32'hCCCC_0003);
    poke(5, 32'hDDDD_0004);
    issue(MODE_COPY, 2, 10, 4, '0, -1, 1'b1);
    settle_and_compare("copy");

    // Fill across the top of memory
    issue(MODE_FILL, 0, 30, 4, 32'hDEAD_BEEF, -1, 1'b1);
    settle_and_compare("fill_wrap");

    // Zero length and rejected length
    issue(MODE_COPY, 7, 9, 0, '0, -1, 1'b1);
    settle_and_compare("len0");
    issue(MODE_FILL, 7, 9, 33, 32'h1234_5678, -1, 1'b1);
    settle_and_compare("len33");

    // Full-depth self copy
    issue(MODE_COPY, 0, 0, 32, '0, -1, 1'b1);
    settle_and_compare("full");

    // Start while busy is ignored, then reset during the third write
    wr_base = wr_seen;
    issue(MODE_COPY, 4, 20, 8, '0, 2, 1'b0);
    @(negedge clk);
    start      = 1'b1;
    mode       = MODE_FILL;
    len        = 6'd3;
    dst_base   = 5'd1;
    fill_value = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #2;
      if (mif.MemWrite && wr_seen == wr_base + 2) break;
      n++;
    end
    chk("third_write_reached", 64'(n < 60), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_memwrite", {63'd0, mif.MemWrite}, 64'd0);
    chk("rst_mid_memread", {63'd0, mif.MemRead}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    settle_and_compare("reset_mid");

    issue(MODE_FILL, 0, 3, 5, 32'h0F0F_0F0F, -1, 1'b1);
    settle_and_compare("after_reset");

    // Randomized operations, including overlap, wrap, zero and rejected lengths
    for (int t = 0; t < 12; t++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 34)), $urandom, -1, 1'b1);
      settle_and_compare($sformatf("rand%0d", t));
    end

    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("err_queue_empty", 64'(eq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
